// File: rtl/fma_issue_ctrl.sv
// fma_issue_ctrl
//   Sequencing and arbitration controller for a pipelined FMA datapath
//   (multiply/align, significand add, normalize/round). Two requesters
//   share the unit through round-robin arbitration. The block tracks the
//   valid/tag/source of each stage and produces pipeline-register enables.
//
// Handshakes (valid/ready):
//   Request side:  op i is accepted on a rising clk edge where
//                  ReqValid[i] & ReqReady[i]. ReqReady never depends on
//                  accepting the op; it is one-hot or zero.
//   Response side: a result is delivered on a rising clk edge where
//                  RespValid & RespReady. While RespValid & ~RespReady,
//                  RespTag/RespSrc and every stage hold unchanged.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   ReqValid[2]    per-requester operation valid
//   ReqTag0/1      requester tags carried alongside the op
//   ReqReady[2]    one-hot grant
//   IssueSel       stage-0 operand mux select (granted index, else pointer)
//   StageEn        datapath pipeline register load enables
//   StageValid     per-stage valid (bit 0 = first stage)
//   RespValid      final stage holds a result
//   RespReady      consumer accepts the result
//   RespSrc/Tag    requester index and tag of the final-stage op
//   Flush          kill all in-flight ops, no grant this cycle
//   Busy           any stage valid
module fma_issue_ctrl #(
  parameter int NSTAGE = 3,
  parameter int TAGW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ReqValid,
  input  logic [TAGW-1:0]   ReqTag0,
  input  logic [TAGW-1:0]   ReqTag1,
  output logic [1:0]        ReqReady,
  output logic              IssueSel,
  output logic [NSTAGE-1:0] StageEn,
  output logic [NSTAGE-1:0] StageValid,
  output logic              RespValid,
  input  logic              RespReady,
  output logic              RespSrc,
  output logic [TAGW-1:0]   RespTag,
  input  logic              Flush,
  output logic              Busy
);

  logic [NSTAGE-1:0] stage_valid;
  logic [TAGW-1:0]   stage_tag [NSTAGE];
  logic              stage_src [NSTAGE];
  logic              rr_ptr;     // requester preferred when both are valid

  logic              adv;
  logic              grant_any;
  logic              grant_sel;
  logic [TAGW-1:0]   grant_tag;

  // The whole pipe moves together: it advances whenever the final stage is
  // empty or its result is being taken. No bubble collapse.
  assign adv = ~stage_valid[NSTAGE-1] | RespReady;

  always_comb begin
    grant_sel = 1'b0;
    if (ReqValid == 2'b11) begin
      grant_sel = rr_ptr;
    end else if (ReqValid[1]) begin
      grant_sel = 1'b1;
    end
  end

  assign grant_any = adv & ~Flush & ~reset & (|ReqValid);
  assign grant_tag = grant_sel ? ReqTag1 : ReqTag0;

  always_comb begin
    ReqReady = 2'b00;
    if (grant_any) begin
      ReqReady = grant_sel ? 2'b10 : 2'b01;
    end
  end

  // With no grant the mux select parks on the pointer; data is don't-care.
  assign IssueSel = grant_any ? grant_sel : rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= '0;
      rr_ptr      <= 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        stage_tag[k] <= '0;
        stage_src[k] <= 1'b0;
      end
    end else if (Flush) begin
      // A handshake completing this cycle is still delivered; everything
      // else in flight is dropped. Tags are left as-is since no valid bit
      // qualifies them. No grant happens, so the pointer holds.
      stage_valid <= '0;
    end else if (adv) begin
      stage_valid[0] <= grant_any;
      stage_tag[0]   <= grant_tag;
      stage_src[0]   <= grant_sel;
      for (int k = 1; k < NSTAGE; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_tag[k]   <= stage_tag[k-1];
        stage_src[k]   <= stage_src[k-1];
      end
      if (grant_any) begin
        rr_ptr <= ~grant_sel;
      end
    end
  end

  assign StageEn    = {NSTAGE{adv}};
  assign StageValid = stage_valid;
  assign RespValid  = stage_valid[NSTAGE-1];
  assign RespTag    = stage_tag[NSTAGE-1];
  assign RespSrc    = stage_src[NSTAGE-1];
  assign Busy       = |stage_valid;

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Testbench for fma_issue_ctrl: directed scenarios with literal expectations
// plus a per-cycle comparison against a queue-based model of in-flight ops.
module tb_fma_issue_ctrl;
  localparam int NSTAGE = 3;
  localparam int TAGW   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [1:0]        ReqValid = 2'b00;
  logic [TAGW-1:0]   ReqTag0 = '0;
  logic [TAGW-1:0]   ReqTag1 = '0;
  logic [1:0]        ReqReady;
  logic              IssueSel;
  logic [NSTAGE-1:0] StageEn;
  logic [NSTAGE-1:0] StageValid;
  logic              RespValid;
  logic              RespReady = 1'b0;
  logic              RespSrc;
  logic [TAGW-1:0]   RespTag;
  logic              Flush = 1'b0;
  logic              Busy;

  fma_issue_ctrl #(.NSTAGE(NSTAGE), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqTag0(ReqTag0),
    .ReqTag1(ReqTag1), .ReqReady(ReqReady), .IssueSel(IssueSel),
    .StageEn(StageEn), .StageValid(StageValid), .RespValid(RespValid),
    .RespReady(RespReady), .RespSrc(RespSrc), .RespTag(RespTag),
    .Flush(Flush), .Busy(Busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: ops in flight, oldest first ----------------
  typedef struct {
    logic [TAGW-1:0] tag;
    logic            src;
    int              pos;   // stage index the op occupies
  } op_t;

  op_t  ops[$];
  logic m_ptr = 1'b0;
  bit   started = 0;
  int   n_acc = 0, n_resp = 0, n_flush = 0;
  int   wait_cnt [2] = '{0, 0};

  // Checks happen at the falling edge (inputs were driven just after the
  // rising edge), then the model steps to the state after the next rising edge.
  always @(negedge clk) begin
    bit              last_full;
    bit              m_adv, m_grant;
    logic            m_sel;
    logic [1:0]      exp_ready;
    logic [NSTAGE-1:0] exp_sv;
    op_t             o;

    last_full = (ops.size() > 0) && (ops[0].pos == NSTAGE-1);
    m_adv     = !last_full || RespReady;
    m_grant   = !reset && !Flush && m_adv && (ReqValid != 2'b00);
    m_sel     = (ReqValid == 2'b11) ? m_ptr : ReqValid[1];

    if (started) begin
      exp_ready = m_grant ? (m_sel ? 2'b10 : 2'b01) : 2'b00;
      exp_sv = '0;
      foreach (ops[i]) exp_sv[ops[i].pos] = 1'b1;
      check("ReqReady", ReqReady, exp_ready);
      check("IssueSel", IssueSel, m_grant ? m_sel : m_ptr);
      check("StageEn", StageEn, m_adv ? {NSTAGE{1'b1}} : '0);
      check("StageValid", StageValid, exp_sv);
      check("RespValid", RespValid, last_full);
      check("Busy", Busy, ops.size() != 0);
      if (last_full) begin
        check("RespTag", RespTag, ops[0].tag);
        check("RespSrc", RespSrc, ops[0].src);
      end
      check("invariant", n_acc - n_resp - n_flush, $countones(StageValid));
      for (int i = 0; i < 2; i++) begin
        if (!reset && !Flush && m_adv && ReqValid[i]) begin
          if (m_sel == i[0]) wait_cnt[i] = 0;
          else begin
            wait_cnt[i]++;
            check("starvation", wait_cnt[i] <= 2, 1);
          end
        end
      end
    end

    // step the model
    if (reset) begin
      ops.delete();
      m_ptr = 1'b0;
      n_acc = 0; n_resp = 0; n_flush = 0;
      wait_cnt[0] = 0; wait_cnt[1] = 0;
      started = 1;
    end else if (Flush) begin
      if (last_full && RespReady) n_resp++;
      n_flush += ops.size() - ((last_full && RespReady) ? 1 : 0);
      ops.delete();
    end else if (m_adv) begin
      if (last_full) begin
        void'(ops.pop_front());
        n_resp++;
      end
      foreach (ops[i]) ops[i].pos++;
      if (m_grant) begin
        o.tag = m_sel ? ReqTag1 : ReqTag0;
        o.src = m_sel;
        o.pos = 0;
        ops.push_back(o);
        n_acc++;
        m_ptr = ~m_sel;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ReqValid = 2'b00; Flush = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    ReqValid = 2'b00;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [TAGW-1:0] tag_tbl [4];
    logic [1:0]      gnt_tbl [4];

    cyc(); cyc();
    reset = 1'b0;
    @(negedge clk);
    check("rst_StageValid", StageValid, 3'b000);
    check("rst_RespValid", RespValid, 0);
    check("rst_RespTag", RespTag, 0);
    check("rst_RespSrc", RespSrc, 0);
    check("rst_Busy", Busy, 0);
    cyc();

    // single op, latency NSTAGE
    RespReady = 1'b1; ReqValid = 2'b01; ReqTag0 = 4'd5;
    @(negedge clk); check("t1_grant", ReqReady, 2'b01);
    cyc(); ReqValid = 2'b00;
    cyc(); cyc();
    @(negedge clk);
    check("t1_RespValid", RespValid, 1);
    check("t1_RespSrc", RespSrc, 0);
    check("t1_RespTag", RespTag, 5);
    cyc();
    @(negedge clk); check("t1_Busy", Busy, 0);
    cyc();

    // both requesters: alternate grants, in-order responses
    do_reset();
    gnt_tbl = '{2'b01, 2'b10, 2'b01, 2'b10};
    tag_tbl = '{4'd1, 4'd9, 4'd1, 4'd9};
    ReqTag0 = 4'd1; ReqTag1 = 4'd9; RespReady = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ReqValid = (i < 4) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (i < 4) check("t2_grant", ReqReady, gnt_tbl[i]);
      if (i >= 3) begin
        check("t2_RespValid", RespValid, 1);
        check("t2_RespTag", RespTag, tag_tbl[i-3]);
        check("t2_RespSrc", RespSrc, (i - 3) % 2);
      end
      cyc();
    end
    check("t2_model_resp", n_resp, 4);

    // backpressure with a full pipe
    do_reset();
    RespReady = 1'b0; ReqValid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      ReqTag0 = 4'(i + 1);
      @(negedge clk); check("t3_fill_grant", ReqReady, 2'b01);
      cyc();
    end
    ReqTag0 = 4'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_tag", RespTag, 1);
      check("t3_hold_sv", StageValid, 3'b111);
      check("t3_hold_ready", ReqReady, 2'b00);
      cyc();
    end
    RespReady = 1'b1;
    @(negedge clk);
    check("t3_out1", RespTag, 1);
    check("t3_issue_same_cycle", ReqReady, 2'b01);
    cyc(); ReqValid = 2'b00;
    @(negedge clk); check("t3_out2", RespTag, 2);
    cyc();
    @(negedge clk); check("t3_out3", RespTag, 3);
    cyc();
    @(negedge clk); check("t3_out4", RespTag, 4);
    cyc();

    // flush keeps the pointer
    do_reset();
    RespReady = 1'b1; ReqValid = 2'b01;
    ReqTag0 = 4'd6; cyc();
    ReqTag0 = 4'd7; cyc();
    Flush = 1'b1; ReqValid = 2'b11; ReqTag1 = 4'd8;
    @(negedge clk);
    check("t4_flush_ready", ReqReady, 2'b00);
    check("t4_flush_issuesel", IssueSel, 1);
    cyc(); Flush = 1'b0;
    @(negedge clk);
    check("t4_sv_cleared", StageValid, 3'b000);
    check("t4_ptr_kept", ReqReady, 2'b10);
    cyc();
    idle(4);

    // reset mid-operation with a pending response
    RespReady = 1'b0; ReqValid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      ReqTag0 = 4'(10 + i);
      cyc();
    end
    @(negedge clk); check("t5_pending", RespValid, 1);
    reset = 1'b1; ReqValid = 2'b11;
    @(negedge clk); check("t5_rst_ready", ReqReady, 2'b00);
    cyc(); reset = 1'b0; RespReady = 1'b1; ReqTag0 = 4'd2;
    @(negedge clk);
    check("t5_sv", StageValid, 3'b000);
    check("t5_rv", RespValid, 0);
    check("t5_tag", RespTag, 0);
    check("t5_ptr0", ReqReady, 2'b01);
    cyc();
    idle(5);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      ReqValid  = 2'($urandom_range(0, 3));
      ReqTag0   = TAGW'($urandom_range(0, 15));
      ReqTag1   = TAGW'($urandom_range(0, 15));
      RespReady = ($urandom_range(0, 3) != 0);
      Flush     = ($urandom_range(0, 49) == 0);
      cyc();
    end
    Flush = 1'b0; RespReady = 1'b1;
    idle(6);
    @(negedge clk); check("end_idle", Busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fma_issue_ctrl.md
Name: fma_issue_ctrl

Overview:
- Sequencing and arbitration controller for the pipelined FMA datapath: multiply/align stage, significand add stage, normalize/round stage.
- Shares the single FMA unit between two requesters: req 0 = main FPU issue, req 1 = secondary FP issue (vector/replay path), using round-robin arbitration.
- Tracks per-stage valid/tag/source and generates the pipeline-register enables.
- Stalls all stages on result backpressure; supports a global flush.

Parameters:
- NSTAGE, 3, number of FMA pipeline stages tracked (≥2).
- TAGW, 4, width of requester-supplied operation tag carried alongside data.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- ReqValid  input  2  per-requester operation valid
- ReqTag0  input  TAGW  tag of requester 0 op
- ReqTag1  input  TAGW  tag of requester 1 op
- ReqReady  output  2  one-hot grant; op accepted this cycle when ReqValid[i]&ReqReady[i]
- IssueSel  output  1  operand-mux select into stage 0 (0=req0, 1=req1); valid when |ReqReady
- StageEn  output  NSTAGE  load enable for each datapath pipeline register
- StageValid  output  NSTAGE  valid bit per stage (bit 0 = first stage)
- RespValid  output  1  result valid at final stage
- RespReady  input  1  consumer accepts result
- RespSrc  output  1  requester index of final-stage op
- RespTag  output  TAGW  tag of final-stage op
- Flush  input  1  kill all in-flight ops and block issue this cycle
- Busy  output  1  any stage valid

Behaviour:
- Reset (sync, clk edge with reset=1): all StageValid=0, stage tags/srcs=0, round-robin pointer=0 (req0 preferred). Outputs then: RespValid=0, RespTag=0, RespSrc=0, Busy=0. ReqReady=0 while reset asserted. Reset mid-operation discards all in-flight ops; no response is produced for them.
- Advance: Adv = ~StageValid[NSTAGE-1] | RespReady. Pipeline stalls globally; there is no bubble collapse. StageEn[k] = Adv for every k.
- On Adv, stage k+1 takes the valid/tag/src of stage k. Stage 0 takes the granted op, or valid=0 if there is no grant.
- Grant: only when Adv & ~Flush & ~reset.
  - Single requester valid: grant it.
  - Both valid: grant the pointer's requester.
  - After a grant to req i, pointer = ~i.
  - Pointer holds when there is no grant.
  - ReqReady is one-hot or zero, and combinational from ReqValid, pointer, Adv and Flush.
- IssueSel = granted index. When there is no grant, IssueSel = pointer (don't-care for data).
- Latency: op accepted in cycle t, no stall → RespValid=1 in cycle t+NSTAGE. Throughput is one op per cycle. Ops complete in issue order.
- Response: RespValid = StageValid[NSTAGE-1]; RespTag/RespSrc from the final stage. A response completes on RespValid&RespReady. RespValid & ~RespReady holds all stages and tags unchanged.
- Flush: at the clk edge, all StageValid cleared and no grant that cycle; pointer unchanged. A response handshake in the flush cycle still counts as delivered.
  - Flush with reset: reset dominates (same result).
- Full pipeline + RespReady=1: final op retires and a new op issues in the same cycle. Full + RespReady=0: ReqReady=0.
- Busy = |StageValid.
- Invariant for verification: (#accepted − #responded − #flushed) == popcount(StageValid).

Test Plan:
- Reset, then ReqValid=01, ReqTag0=5 for one cycle, RespReady=1 → ReqReady=01 at t0; RespValid=1, RespSrc=0, RespTag=5 at t0+3; Busy low at t0+4.
- Both requesters valid for 4 cycles, tags req0=1, req1=9, RespReady=1 → grants 01,10,01,10; responses in order with tags 1,9,1,9 at t+3..t+6.
- Fill the pipe with tags 1,2,3 from req0; hold RespReady=0 for 5 cycles with ReqValid=01 → RespTag stays 1, StageValid=111, ReqReady=00. RespReady=1 → tags 1,2,3 emerge on consecutive cycles and a new op is accepted in the same cycle tag 1 retires.
- Pipe holds 2 ops, assert Flush for one cycle with ReqValid=11 → ReqReady=00 that cycle; StageValid=000 next cycle; pointer unchanged, so the next grant goes to the same requester as before the flush.
- Assert reset for one cycle while 3 ops are in flight and RespValid=1 → next cycle StageValid=000, RespValid=0, pointer=0; no stale responses ever appear.
- Random ReqValid/RespReady/Flush for 10k cycles → in-order tags per source, invariant holds, and no requester goes ungranted for more than 2 grant opportunities.
